// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared hazard-unit types and forwarding-select encodings
package pipeline_pkg;
    typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} hz_state_t;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/forward_sel.sv
// forward_sel: picks the freshest producer of one EX operand; MEM beats WB, r0 never forwarded
module forward_sel
    import pipeline_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] src_i,
    input  logic [W-1:0] mem_wba_i,
    input  logic         mem_regwen_i,
    input  logic         mem_memtoreg_i,
    input  logic [W-1:0] wb_wba_i,
    input  logic         wb_regwen_i,
    output logic [1:0]   sel_o
);
    logic mem_hit;
    logic wb_hit;
    assign mem_hit = mem_regwen_i && mem_wba_i != W'(REG_ZERO) && !mem_memtoreg_i && mem_wba_i == src_i;
    assign wb_hit  = wb_regwen_i && wb_wba_i != W'(REG_ZERO) && wb_wba_i == src_i;
    assign sel_o   = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: stage enables, flushes, forwarding, memory-wait watchdog and stall counter
module pipeline_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [ADDR_W-1:0] ex_rs,
    input  logic [ADDR_W-1:0] ex_rt,
    input  logic [ADDR_W-1:0] ex_wba,
    input  logic              ex_regWen,
    input  logic              ex_MemtoReg,
    input  logic [ADDR_W-1:0] mem_wba,
    input  logic              mem_regWen,
    input  logic              mem_MemtoReg,
    input  logic [ADDR_W-1:0] wb_wba,
    input  logic              wb_regWen,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [1:0]        fwdA,
    output logic [1:0]        fwdB,
    output logic              mem_fault,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int WC_W = $clog2(MEM_TIMEOUT);
    hz_state_t        state_q;
    logic [WC_W-1:0]  wait_cnt_q;
    logic             mem_fault_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             memstall;
    logic             frozen;
    logic             loaduse;

    forward_sel #(.W(ADDR_W)) u_fwd_a (
        .src_i(ex_rs), .mem_wba_i(mem_wba), .mem_regwen_i(mem_regWen), .mem_memtoreg_i(mem_MemtoReg),
        .wb_wba_i(wb_wba), .wb_regwen_i(wb_regWen), .sel_o(fwd_a)
    );
    forward_sel #(.W(ADDR_W)) u_fwd_b (
        .src_i(ex_rt), .mem_wba_i(mem_wba), .mem_regwen_i(mem_regWen), .mem_memtoreg_i(mem_MemtoReg),
        .wb_wba_i(wb_wba), .wb_regwen_i(wb_regWen), .sel_o(fwd_b)
    );

    assign memstall = mem_req && !mem_ready;
    assign frozen   = memstall || state_q == TIMEOUT;
    assign loaduse  = ex_regWen && ex_MemtoReg && ex_wba != ADDR_W'(REG_ZERO)
                      && (ex_wba == id_rs || (id_uses_rt && ex_wba == id_rt));
    assign fwdA      = reset ? FWD_RF : fwd_a;
    assign fwdB      = reset ? FWD_RF : fwd_b;
    assign mem_fault = mem_fault_q;
    assign stall_cnt = stall_cnt_q;

    // Control priority: memory freeze, then branch squash, then load-use bubble
    always_comb begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
        {if_id_flush, id_ex_flush} = 2'b00;
        if (!reset) begin
            if (frozen) begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
            end else if (ex_branch_taken) begin
                {if_id_flush, id_ex_flush} = 2'b11;
            end else if (loaduse) begin
                {pc_en, if_id_en} = 2'b00;
                id_ex_flush = 1'b1;
            end
        end
    end

    // Saturating count of cycles the PC is held
    always_comb begin
        stall_cnt_d = reset ? '0 : (!pc_en && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    // Stall counter register, same edge as the pipeline registers
    always_ff @(negedge clk) begin
        stall_cnt_q <= stall_cnt_d;
    end

    // Memory-wait watchdog; TIMEOUT holds until reset
    always_ff @(negedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (memstall) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_req || mem_ready) begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
                        state_q     <= TIMEOUT;
                        mem_fault_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WC_W'(1);
                    end
                end
                default: mem_fault_q <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: directed vectors with hand-computed expectations
module tb_pipeline_hazard_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wba, mem_wba, wb_wba;
    logic       id_uses_rt, ex_regWen, ex_MemtoReg, mem_regWen, mem_MemtoReg, wb_regWen;
    logic       ex_branch_taken, mem_req, mem_ready;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
    logic [1:0] fwdA, fwdB;
    logic       mem_fault;
    logic [15:0] stall_cnt;
    logic [6:0] ctl;
    int n_cmp = 0;
    int n_err = 0;

    localparam logic [6:0] CTL_RUN    = 7'b11111_00;
    localparam logic [6:0] CTL_LOADUSE = 7'b00111_01;
    localparam logic [6:0] CTL_BRANCH = 7'b11111_11;
    localparam logic [6:0] CTL_FROZEN = 7'b00000_00;

    pipeline_hazard_unit dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wba(ex_wba), .ex_regWen(ex_regWen), .ex_MemtoReg(ex_MemtoReg),
        .mem_wba(mem_wba), .mem_regWen(mem_regWen), .mem_MemtoReg(mem_MemtoReg),
        .wb_wba(wb_wba), .wb_regWen(wb_regWen), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .if_id_en(if_id_en),
        .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .fwdA(fwdA), .fwdB(fwdB),
        .mem_fault(mem_fault), .stall_cnt(stall_cnt)
    );

    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

    // Free-running clock; the design acts on the falling edge
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {id_rs, id_rt, ex_rs, ex_rt, ex_wba, mem_wba, wb_wba} = '0;
        {id_uses_rt, ex_regWen, ex_MemtoReg, mem_regWen, mem_MemtoReg, wb_regWen} = '0;
        {ex_branch_taken, mem_req, mem_ready} = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        mem_req = 1'b1;
        mem_wba = 5'd5; mem_regWen = 1'b1; ex_rs = 5'd5;
        #1;
        check("reset_ctl", ctl, CTL_RUN);
        check("reset_fwdA", fwdA, 2'b00);
        step(2);
        clear_inputs();
        reset = 1'b0;
        #1;
        check("post_reset_cnt", stall_cnt, 0);
        check("post_reset_fault", mem_fault, 0);
        check("post_reset_ctl", ctl, CTL_RUN);

        mem_wba = 5'd5; mem_regWen = 1'b1; wb_wba = 5'd5; wb_regWen = 1'b1; ex_rs = 5'd5; ex_rt = 5'd5;
        #1;
        check("fwdA_mem", fwdA, 2'b01);
        check("fwdB_mem", fwdB, 2'b01);
        mem_regWen = 1'b0;
        #1;
        check("fwdA_wb", fwdA, 2'b10);
        ex_rs = 5'd0;
        #1;
        check("fwdA_r0", fwdA, 2'b00);
        ex_rs = 5'd5; mem_regWen = 1'b1; mem_MemtoReg = 1'b1; ex_rt = 5'd3;
        #1;
        check("fwdA_memload_wb", fwdA, 2'b10);
        check("fwdB_none", fwdB, 2'b00);
        mem_wba = 5'd0; wb_wba = 5'd0; mem_MemtoReg = 1'b0; ex_rs = 5'd0;
        #1;
        check("fwdA_r0_both", fwdA, 2'b00);
        clear_inputs();

        id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1'b1;
        ex_regWen = 1'b1; ex_MemtoReg = 1'b1; ex_wba = 5'd7;
        #1;
        check("loaduse_ctl", ctl, CTL_LOADUSE);
        step(1);
        check("loaduse_cnt", stall_cnt, 1);
        ex_MemtoReg = 1'b0;
        #1;
        check("after_bubble_ctl", ctl, CTL_RUN);
        ex_MemtoReg = 1'b1; id_uses_rt = 1'b0;
        #1;
        check("no_rt_use_ctl", ctl, CTL_RUN);
        step(1);
        check("no_rt_use_cnt", stall_cnt, 1);
        id_uses_rt = 1'b1; ex_branch_taken = 1'b1;
        #1;
        check("branch_over_loaduse", ctl, CTL_BRANCH);
        step(1);
        check("branch_cnt", stall_cnt, 1);
        clear_inputs();

        do_reset();
        mem_req = 1'b1; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("memwait_ctl", ctl, CTL_FROZEN);
            step(1);
        end
        mem_ready = 1'b1;
        #1;
        check("release_branch_ctl", ctl, CTL_BRANCH);
        step(1);
        check("memwait_cnt", stall_cnt, 3);
        clear_inputs();

        mem_req = 1'b1;
        step(2);
        mem_req = 1'b0;
        #1;
        check("req_drop_ctl", ctl, CTL_RUN);
        step(1);
        mem_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            check("timeout_fault", mem_fault, (i == 16) ? 1 : 0);
        end
        mem_ready = 1'b1;
        #1;
        check("timeout_frozen", ctl, CTL_FROZEN);
        step(1);
        check("timeout_sticky", mem_fault, 1);
        check("timeout_still_frozen", ctl, CTL_FROZEN);
        reset = 1'b1;
        #1;
        check("reset_over_timeout", ctl, CTL_RUN);
        step(1);
        reset = 1'b0;
        #1;
        check("fault_cleared", mem_fault, 0);
        check("cnt_cleared", stall_cnt, 0);
        check("run_after_reset", ctl, CTL_RUN);
        clear_inputs();

        id_rs = 5'd9; ex_regWen = 1'b1; ex_MemtoReg = 1'b1; ex_wba = 5'd9;
        step(65534);
        check("cnt_fffe", stall_cnt, 16'hFFFE);
        step(1);
        check("cnt_ffff", stall_cnt, 16'hFFFF);
        step(2);
        check("cnt_saturated", stall_cnt, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Control-side consumer of the ID/EX pipeline register outputs.
- Reads the register/control fields that ID/EX, EX/MEM and MEM/WB present to the EX stage, and drives per-stage enables, flushes and forwarding selects back into the pipeline.
- Handles load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
- Keeps a memory-wait timeout watchdog and a stall performance counter.

Parameters:
- ADDR_W, 5, register-address width.
- MEM_TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before fault.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; state updates on negedge, same edge as the pipeline registers.
- reset  in  1  reset, synchronous, active-high.
- id_rs, id_rt  in  ADDR_W  source registers of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt.
- ex_rs, ex_rt  in  ADDR_W  ID/EX q_rs, q_rt.
- ex_wba  in  ADDR_W  ID/EX q_wba.
- ex_regWen, ex_MemtoReg  in  1  ID/EX q_regWen, q_MemtoReg.
- mem_wba  in  ADDR_W  EX/MEM write-back address.
- mem_regWen, mem_MemtoReg  in  1  EX/MEM controls.
- wb_wba  in  ADDR_W  MEM/WB write-back address.
- wb_regWen  in  1  MEM/WB write enable.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  data-memory access in progress in MEM.
- mem_ready  in  1  data memory completes this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage enables.
- if_id_flush, id_ex_flush  out  1  bubble-insert requests.
- fwdA, fwdB  out  2  EX operand select: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
- mem_fault  out  1  sticky timeout fault.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0.

Behaviour:
- Forwarding (combinational), fwdA shown; fwdB is identical using ex_rt:
  - 01 if mem_regWen && mem_wba!=0 && !mem_MemtoReg && mem_wba==ex_rs.
  - else 10 if wb_regWen && wb_wba!=0 && wb_wba==ex_rs.
  - else 00.
  - MEM has priority over WB. Register 0 is never forwarded.
- Conditions (combinational):
  - memstall = mem_req && !mem_ready.
  - loaduse = ex_regWen && ex_MemtoReg && ex_wba!=0 && (ex_wba==id_rs || (id_uses_rt && ex_wba==id_rt)).
  - branch = ex_branch_taken.
- Priority 1, memstall or state TIMEOUT:
  - all five enables 0, both flushes 0.
  - A taken branch stays frozen in EX and is handled after release.
- Priority 2, branch:
  - all enables 1, if_id_flush=1, id_ex_flush=1 for exactly that cycle.
  - Overrides loaduse, because the dependent instruction is squashed.
- Priority 3, loaduse:
  - pc_en=0, if_id_en=0, id_ex_flush=1; id_ex_en, ex_mem_en, mem_wb_en stay 1.
  - Costs exactly one bubble; next cycle the load is in MEM and forwarding takes over.
- Otherwise: all enables 1, flushes 0.
- FSM states RUN, MEM_WAIT, TIMEOUT; wait_cnt is log2(MEM_TIMEOUT) bits.
  - RUN: memstall leads to MEM_WAIT with wait_cnt=1.
  - MEM_WAIT, mem_ready=1: go to RUN, wait_cnt=0; enables resume in that same cycle.
  - MEM_WAIT, mem_ready=0 and wait_cnt==MEM_TIMEOUT-1: go to TIMEOUT, mem_fault=1.
  - MEM_WAIT otherwise: wait_cnt+1.
  - mem_req dropping while in MEM_WAIT returns the FSM to RUN.
  - TIMEOUT: absorbing until reset; pipeline frozen; mem_fault held 1.
- stall_cnt increments on every clock edge where pc_en=0 and saturates at all-ones.
- Reset:
  - state RUN, wait_cnt 0, stall_cnt 0, mem_fault 0.
  - While reset is asserted, outputs are: enables 1, flushes 0, fwdA/fwdB 00.
  - Reset during MEM_WAIT or TIMEOUT clears state on that edge.

Decomposition:
- Shared package pipeline_pkg:
  - state enum hz_state_t {RUN, MEM_WAIT, TIMEOUT}.
  - forwarding-select constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - REG_ZERO constant.
- One natural sub-module, forward_sel: a purely combinational single-operand forwarding selector, instantiated twice for A and B.

Test Plan:
- mem_wba=5, mem_regWen=1, mem_MemtoReg=0, wb_wba=5, wb_regWen=1, ex_rs=5 -> fwdA=01. Clear mem_regWen -> fwdA=10. With ex_rs=0 -> fwdA=00.
- ex_MemtoReg=1, ex_regWen=1, ex_wba=7, id_rt=7, id_uses_rt=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt=1. With id_uses_rt=0 -> no stall.
- Load-use condition plus ex_branch_taken=1 in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1, stall_cnt unchanged.
- mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 -> all enables 0 for 3 cycles, resume on the 4th, state back to RUN, stall_cnt=3.
- mem_req=1, mem_ready stuck 0 for 16 cycles -> mem_fault=1 and pipeline frozen. Later mem_ready=1 -> still frozen. reset -> mem_fault=0, state RUN.
- Preload stall_cnt to 16'hFFFE, then 3 stall cycles -> stall_cnt=16'hFFFF (saturated).
